// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// The Moore control word is registered together with the state. The write enables
// are then gated combinationally by (run & ~rst), so a frozen or resetting CPU
// never writes anything.
module multicycle_control #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [5:0]           opcode,
    output logic                 PCWrite,
    output logic                 Branch,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic                 ALUOp1,
    output logic                 ALUOp0,
    output logic [1:0]           PCSrc,
    output logic [3:0]           state,
    output logic                 instr_done,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] instr_cnt
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    state_e                state_q, state_d;
    ctrl_t                 ctrl_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  go;
    logic                  op_legal;
    logic                  retire_state;
    logic                  bad_decode;

    // Moore control word for a given state; unreachable encodings drive nothing.
    function automatic ctrl_t ctrl_of(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            StDecode: c.alu_src_b = 2'b11;
            StMemAdr: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            StMemRd: begin
                c.ior_d    = 1'b1;
                c.mem_read = 1'b1;
            end
            StMemWb: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            StMemWr: begin
                c.ior_d     = 1'b1;
                c.mem_write = 1'b1;
            end
            StExec: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            StAluWb: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            StBranch: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            StAddiEx: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            StAddiWb: c.reg_write = 1'b1;
            StJump: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign go       = run & ~rst;
    assign op_legal = (opcode == OpRtype) || (opcode == OpLw) || (opcode == OpSw) ||
                      (opcode == OpBeq) || (opcode == OpAddi) || (opcode == OpJ);

    // Next-state selection; opcode is only consulted while the IR is stable.
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                if (opcode == OpLw || opcode == OpSw) state_d = StMemAdr;
                else if (opcode == OpRtype)           state_d = StExec;
                else if (opcode == OpBeq)             state_d = StBranch;
                else if (opcode == OpAddi)            state_d = StAddiEx;
                else if (opcode == OpJ)               state_d = StJump;
                else                                  state_d = StFetch;
            end
            StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:  state_d = StMemWb;
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            default:  state_d = StFetch;
        endcase
    end

    // State, registered control word and retire counter; everything holds while run=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            ctrl_q  <= ctrl_of(StFetch);
            cnt_q   <= '0;
        end else if (run) begin
            state_q <= state_d;
            ctrl_q  <= ctrl_of(state_d);
            if (instr_done) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    // Retire and illegal detection, combinational in the instruction's last cycle.
    always_comb begin
        retire_state = (state_q == StMemWb) || (state_q == StMemWr) ||
                       (state_q == StAluWb) || (state_q == StBranch) ||
                       (state_q == StAddiWb) || (state_q == StJump);
        bad_decode   = (state_q == StDecode) && !op_legal;
        instr_done   = go & (retire_state | bad_decode);
        illegal      = go & bad_decode;
    end

    assign PCWrite   = ctrl_q.pc_write  & go;
    assign Branch    = ctrl_q.branch    & go;
    assign IRWrite   = ctrl_q.ir_write  & go;
    assign MemWrite  = ctrl_q.mem_write & go;
    assign RegWrite  = ctrl_q.reg_write & go;
    assign IorD      = ctrl_q.ior_d;
    assign MemRead   = ctrl_q.mem_read;
    assign RegDst    = ctrl_q.reg_dst;
    assign MemtoReg  = ctrl_q.mem_to_reg;
    assign ALUSrcA   = ctrl_q.alu_src_a;
    assign ALUSrcB   = ctrl_q.alu_src_b;
    assign ALUOp1    = ctrl_q.alu_op[1];
    assign ALUOp0    = ctrl_q.alu_op[0];
    assign PCSrc     = ctrl_q.pc_src;
    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. The reference model tracks each
// instruction as a position within its opcode's state walk. A second instance
// with a 3-bit counter is used to check counter wrap-around.
module tb_multicycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, run;
    logic [5:0] opcode;

    logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, ALUOp1, ALUOp0, instr_done, illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] state;
    logic [31:0] instr_cnt;

    logic       s_pcw, s_br, s_iord, s_mr, s_mw, s_irw, s_rd, s_m2r, s_rw, s_asa, s_op1, s_op0;
    logic       s_done, s_ill;
    logic [1:0] s_asb, s_pcs;
    logic [3:0] s_state;
    logic [2:0] s_cnt;

    multicycle_control #(.CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp1(ALUOp1),
        .ALUOp0(ALUOp0), .PCSrc(PCSrc), .state(state), .instr_done(instr_done),
        .illegal(illegal), .instr_cnt(instr_cnt)
    );

    multicycle_control #(.CNT_WIDTH(3)) dut_small (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .PCWrite(s_pcw), .Branch(s_br), .IorD(s_iord), .MemRead(s_mr),
        .MemWrite(s_mw), .IRWrite(s_irw), .RegDst(s_rd), .MemtoReg(s_m2r),
        .RegWrite(s_rw), .ALUSrcA(s_asa), .ALUSrcB(s_asb), .ALUOp1(s_op1),
        .ALUOp0(s_op0), .PCSrc(s_pcs), .state(s_state), .instr_done(s_done),
        .illegal(s_ill), .instr_cnt(s_cnt)
    );

    // Bit order: PCWrite Branch IorD MemRead MemWrite IRWrite RegDst MemtoReg RegWrite
    //            ALUSrcA ALUSrcB[1:0] ALUOp1 ALUOp0 PCSrc[1:0]
    logic [15:0] got_ctrl;
    assign got_ctrl = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                       RegWrite, ALUSrcA, ALUSrcB, ALUOp1, ALUOp0, PCSrc};
    localparam logic [15:0] WeMask = 16'b1100_1100_1000_0000;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Number of cycles an instruction takes.
    function automatic int seq_len(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return 4;
            6'b001000: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    // State visited at position idx of the instruction's walk.
    function automatic int seq_state(input logic [5:0] op, input int idx);
        if (idx < 2) return idx;
        case (op)
            6'b100011: return idx;                    // 2,3,4
            6'b101011: return (idx == 2) ? 2 : 5;
            6'b000000: return (idx == 2) ? 6 : 7;
            6'b001000: return (idx == 2) ? 9 : 10;
            6'b000100: return 8;
            6'b000010: return 11;
            default:   return 0;
        endcase
    endfunction

    // Control word for each state, straight from the output table.
    function automatic logic [15:0] exp_ctrl(input int s);
        logic [15:0] c;
        c = '0;
        case (s)
            0:  begin c[12] = 1; c[10] = 1; c[15] = 1; c[5:4] = 2'b01; end
            1:  c[5:4] = 2'b11;
            2:  begin c[6] = 1; c[5:4] = 2'b10; end
            3:  begin c[13] = 1; c[12] = 1; end
            4:  begin c[8] = 1; c[7] = 1; end
            5:  begin c[13] = 1; c[11] = 1; end
            6:  begin c[6] = 1; c[3:2] = 2'b10; end
            7:  begin c[9] = 1; c[7] = 1; end
            8:  begin c[6] = 1; c[3:2] = 2'b01; c[1:0] = 2'b01; c[14] = 1; end
            9:  begin c[6] = 1; c[5:4] = 2'b10; end
            10: c[7] = 1;
            11: begin c[1:0] = 2'b10; c[15] = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    int          m_idx = 0;
    logic [31:0] m_cnt = '0;

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input logic r, input logic rs, input logic [5:0] op);
        int   es;
        logic last, g;
        @(negedge clk);
        run = r; rst = rs; opcode = op;
        #2;
        es   = seq_state(op, m_idx);
        last = (m_idx == seq_len(op) - 1);
        g    = r & ~rs;
        check("state", 64'(state), 64'(es));
        check("ctrl", 64'(got_ctrl), 64'(g ? exp_ctrl(es) : (exp_ctrl(es) & ~WeMask)));
        check("instr_done", 64'(instr_done), 64'(g & last));
        check("illegal", 64'(illegal), 64'(g & last & (es == 1)));
        check("instr_cnt", 64'(instr_cnt), 64'(m_cnt));
        check("instr_cnt_wrap", 64'(s_cnt), 64'(m_cnt[2:0]));
        if (rs) begin
            m_idx = 0;
            m_cnt = '0;
        end else if (r) begin
            if (last) begin
                m_idx = 0;
                m_cnt = m_cnt + 1;
            end else begin
                m_idx = m_idx + 1;
            end
        end
    endtask

    logic [5:0] ops [7] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h3f};
    logic [5:0] cur_op;

    initial begin
        rst = 1'b1; run = 1'b0; opcode = '0;
        repeat (2) @(posedge clk);

        step(0, 1, 6'h00);                       // reset with run low
        repeat (4) step(1, 0, 6'h00);            // R-type
        repeat (5) step(1, 0, 6'h23);            // lw
        repeat (4) step(1, 0, 6'h2b);            // sw
        repeat (3) step(1, 0, 6'h04);            // beq
        repeat (3) step(1, 0, 6'h02);            // j
        repeat (2) step(1, 0, 6'h3f);            // unsupported
        repeat (3) step(1, 0, 6'h23);            // lw up to MEMRD
        repeat (4) step(0, 0, 6'h23);            // frozen in MEMRD
        repeat (2) step(1, 0, 6'h23);            // MEMRD, MEMWB
        repeat (2) step(1, 0, 6'h00);            // R-type up to EXEC
        step(1, 1, 6'h00);                       // reset in EXEC
        repeat (4) step(1, 0, 6'h00);            // fresh R-type

        cur_op = 6'h00;
        for (int i = 0; i < 3000; i++) begin
            if (m_idx == 0)
                cur_op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, cur_op);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath built from the existing ALU, Registers, PC, Sign_extend and Mux blocks.
- Sequences add/sub/and/or (R-type), addi, lw, sw, beq and j over 3–5 cycles each.
- A `run` gate lets the debug unit freeze the CPU or step it one cycle at a time.
- Exports state, retire pulse and retire count for the debug display.
- The ALUOp outputs feed the existing ALUControl decoder unchanged.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- run  input  1  advance enable; 0 = freeze.
- opcode  input  6  instr[31:26] from the instruction register.
- PCWrite  output  1  unconditional PC write enable.
- Branch  output  1  conditional PC write; PC is written if Branch & zf.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write enable.
- IRWrite  output  1  instruction register load.
- RegDst  output  1  write address select: 1 = rd, 0 = rt.
- MemtoReg  output  1  write data select: 1 = MDR, 0 = ALUOut.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  ALU A input: 0 = PC, 1 = A register.
- ALUSrcB  output  2  ALU B input: 00 = B, 01 = 4, 10 = sext imm, 11 = sext imm<<2.
- ALUOp1, ALUOp0  output  1 each  to ALUControl.
- PCSrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  output  4  current state encoding.
- instr_done  output  1  one-cycle retire pulse.
- illegal  output  1  one-cycle pulse on an unsupported opcode.
- instr_cnt  output  CNT_WIDTH  retired-instruction count.

Behaviour:
State encoding:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11.
- Encodings 12–15 are unreachable; if entered, the next state is FETCH.

Transitions (taken only when run=1):
- FETCH -> DECODE.
- DECODE dispatches on opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other opcode -> FETCH
- MEMADR -> MEMRD when the latched op is lw, MEMWR when it is sw.
- MEMRD -> MEMWB.
- EXEC -> ALUWB.
- ADDIEX -> ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP -> FETCH.
- opcode is sampled combinationally in DECODE and MEMADR. The IR is stable there because IRWrite is 0.

Moore outputs (any signal not listed for a state is 0):
- FETCH: MemRead, IRWrite, PCWrite; ALUSrcB=01.
- DECODE: ALUSrcB=11.
- MEMADR: ALUSrcA=1, ALUSrcB=10.
- MEMRD: IorD, MemRead.
- MEMWB: MemtoReg, RegWrite.
- MEMWR: IorD, MemWrite.
- EXEC: ALUSrcA=1, ALUOp=10.
- ALUWB: RegDst, RegWrite.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch.
- ADDIEX: ALUSrcA=1, ALUSrcB=10.
- ADDIWB: RegWrite.
- JUMP: PCSrc=10, PCWrite.

Gating of write enables:
- The write enables are PCWrite, Branch, IRWrite, MemWrite and RegWrite.
- They are ANDed with (run & ~rst).
- Select and mux outputs are never gated.

run=0:
- The state register, instr_cnt and all write enables hold.
- Re-asserting run resumes exactly where the FSM stopped; no cycle is lost or repeated.

instr_done:
- Equals run & ~rst & (state ∈ {MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP} OR (state==DECODE & opcode unsupported)).
- It is combinational and asserted in the final cycle of the instruction.

illegal:
- Equals run & ~rst & (state==DECODE) & unsupported opcode.

instr_cnt:
- Registered; increments by 1 on the clock edge where instr_done=1.
- Wraps from all-ones to 0.

Reset:
- With rst=1 at a clock edge: state becomes FETCH and instr_cnt becomes 0, regardless of run.
- While rst=1 all write enables, instr_done and illegal are 0.
- A reset in the middle of an instruction abandons it; no writes occur in the reset cycle.

Latency:
- Cycles per instruction: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.

Test Plan:
- Reset, then run=1 with opcode=000000: state sequence 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7; instr_done pulses once; instr_cnt goes 0->1.
- opcode=100011 (lw): states 0,1,2,3,4,0. In state 3, IorD=1 and MemRead=1. In state 4, MemtoReg=1 and RegWrite=1. Retire occurs on the 5th cycle.
- opcode=101011 (sw) then 000100 (beq) then 000010 (j): MemWrite only in state 5; Branch=1 with PCSrc=01 in state 8; PCWrite=1 with PCSrc=10 in state 11. instr_cnt ends at 3 after 10 cycles.
- opcode=111111: states 0,1,0. illegal=1 and instr_done=1 in state 1. No RegWrite or MemWrite at any point; instr_cnt increments by 1.
- Drop run to 0 in state 3 (lw) for 4 cycles: state stays 3 and all write enables stay 0. When run returns to 1, the next state is 4 with RegWrite=1.
- Assert rst for 1 cycle in state 6 with run=1: no RegWrite; next state 0; instr_cnt=0. Also preload instr_cnt to all-ones and retire one instruction: instr_cnt wraps to 0.
